// File: rtl/exe_shift_buffer_pkg.sv
// Shared constants for the execute-stage shift buffer.
// The helper function sizes the halfword fill counter from the buffer width.
package exe_shift_buffer_pkg;

  localparam int HALF_W        = 16;
  localparam int TS_EIP_OFFSET = 25;

  function automatic int cnt_width(input int buf_width);
    return $clog2(buf_width / HALF_W + 1);
  endfunction

endpackage

// File: rtl/exe_shift_buffer_if.sv
// Push/pop handshake between the execute commands logic and its consumers.
interface exe_shift_buffer_if;

  logic        in_valid;
  logic        in_word;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_word;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output in_valid, in_word, in_data, out_word, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_word, in_data, out_word, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/exe_shift_buffer_rdmux.sv
// Indexed 32-bit field extract from the flat buffer at a halfword offset.
// Bits at or above BUF_WIDTH read as zero.
module exe_shift_buffer_rdmux
  import exe_shift_buffer_pkg::*;
#(
  parameter int BUF_WIDTH = 464,
  parameter int CNT_W     = cnt_width(BUF_WIDTH)
) (
  input  logic [BUF_WIDTH-1:0] sreg,
  input  logic [CNT_W-1:0]     offset,
  output logic [31:0]          data
);

  localparam int CAP = BUF_WIDTH / HALF_W;

  // One zero halfword on top covers the field straddling the MSB end.
  logic [BUF_WIDTH+HALF_W-1:0] padded;

  assign padded = {{HALF_W{1'b0}}, sreg};

  always_comb begin
    data = '0;
    for (int i = 0; i < CAP; i++) begin
      if (offset == CNT_W'(i)) data = padded[i*HALF_W +: 32];
    end
  end

endmodule

// File: rtl/exe_shift_buffer.sv
// Execute-stage state buffer: LSB-side shift-in, oldest-first drain,
// fill tracking and a selectable overflow policy.
module exe_shift_buffer
  import exe_shift_buffer_pkg::*;
#(
  parameter int BUF_WIDTH      = 464,
  parameter bit DISCARD_OLDEST = 1'b1,
  parameter int CNT_W          = cnt_width(BUF_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  exe_shift_buffer_if.slave    bus,
  output logic [CNT_W-1:0]     fill,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  input  logic [CNT_W-1:0]     rd_offset,
  output logic [31:0]          rd_data,
  output logic [BUF_WIDTH-1:0] buf_flat
);

  localparam int             CAP   = BUF_WIDTH / HALF_W;
  localparam logic [CNT_W:0] CAP_X = (CNT_W+1)'(CAP);

  logic [BUF_WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]     fill_q, fill_d;
  logic                 ovf_q, ovf_d;

  logic [CNT_W:0]   fill_x, push_n, pop_n, pop_sub, room_sum, t_sum;
  logic             push_act, pop_act;
  logic [CNT_W-1:0] oldest_off;
  logic [31:0]      oldest;

  assign fill_x  = {1'b0, fill_q};
  assign push_n  = bus.in_word  ? (CNT_W+1)'(1) : (CNT_W+1)'(2);
  assign pop_n   = bus.out_word ? (CNT_W+1)'(1) : (CNT_W+1)'(2);

  assign bus.out_valid = (fill_x >= pop_n);
  assign pop_act       = bus.out_valid & bus.out_ready;
  assign pop_sub       = pop_act ? pop_n : '0;

  // A same-cycle pop frees room for the push in refusal mode.
  assign room_sum     = fill_x - pop_sub + push_n;
  assign bus.in_ready = DISCARD_OLDEST ? 1'b1 : (room_sum <= CAP_X);
  assign push_act     = bus.in_valid & bus.in_ready;

  assign t_sum  = fill_x - pop_sub + (push_act ? push_n : '0);
  assign fill_d = (t_sum > CAP_X) ? CNT_W'(CAP) : t_sum[CNT_W-1:0];

  assign ovf_d = ovf_q | (DISCARD_OLDEST ? (t_sum > CAP_X)
                                         : (bus.in_valid & ~bus.in_ready));

  always_comb begin
    sreg_d = sreg_q;
    if (push_act) begin
      if (bus.in_word) sreg_d = {sreg_q[BUF_WIDTH-17:0], bus.in_data[15:0]};
      else             sreg_d = {sreg_q[BUF_WIDTH-33:0], bus.in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sreg_q <= '0;
      fill_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      fill_q <= fill_d;
      ovf_q  <= ovf_d;
    end
  end

  // Oldest data starts pop_n halfwords below the fill mark; pops never shift.
  assign oldest_off = fill_q - pop_n[CNT_W-1:0];

  exe_shift_buffer_rdmux #(.BUF_WIDTH(BUF_WIDTH), .CNT_W(CNT_W)) u_pop_mux (
    .sreg   (sreg_q),
    .offset (oldest_off),
    .data   (oldest)
  );

  exe_shift_buffer_rdmux #(.BUF_WIDTH(BUF_WIDTH), .CNT_W(CNT_W)) u_rd_mux (
    .sreg   (sreg_q),
    .offset (rd_offset),
    .data   (rd_data)
  );

  assign bus.out_data = !bus.out_valid ? 32'd0
                      : bus.out_word   ? {16'd0, oldest[15:0]}
                      :                  oldest;

  assign fill     = fill_q;
  assign empty    = (fill_q == '0);
  assign full     = (fill_q == CNT_W'(CAP));
  assign overflow = ovf_q;
  assign buf_flat = sreg_q;

endmodule

// File: doc/exe_shift_buffer.md
Name: exe_shift_buffer

Overview:
- Parametrised successor to the execute-stage state buffer used by task switch and descriptor-table stores.
- Accepts dword or word pushes and appends them at the LSB end, as the existing 464-bit shift register does.
- Adds a drain port (oldest-first), a fill counter, full/empty flags, an indexed 32-bit field read, and a selectable overflow policy.
- Sits between the execute commands logic (producer) and the write stage / microcode field extraction (consumers).

Parameters:
- BUF_WIDTH, 464, total buffer bits; must be a multiple of 16. CAP = BUF_WIDTH/16 halfword slots.
- DISCARD_OLDEST, 1, 1 = pushes always accepted and the oldest bits fall off the MSB end (legacy behaviour); 0 = pushes refused when space is insufficient.
- CNT_W, $clog2(BUF_WIDTH/16+1), width of the fill counter in halfwords.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- clear  in  1  synchronous flush.
- in_valid  in  1  push request.
- in_word  in  1  1 = push in_data[15:0] (1 slot); 0 = push in_data[31:0] (2 slots).
- in_data  in  32  push data.
- in_ready  out  1  push will be accepted this cycle.
- out_valid  out  1  enough data is present for the requested pop size.
- out_word  in  1  1 = pop 16 bits; 0 = pop 32 bits.
- out_ready  in  1  consumer takes data.
- out_data  out  32  oldest data; word pops are zero-extended.
- fill  out  CNT_W  occupied halfword slots.
- empty  out  1  fill == 0.
- full  out  1  fill == CAP.
- overflow  out  1  sticky: data was lost or refused.
- rd_offset  in  CNT_W  halfword index of a field in the flat buffer.
- rd_data  out  32  buf[rd_offset*16 +: 32]; bits at or above BUF_WIDTH read as 0.
- buf_flat  out  BUF_WIDTH  raw register contents, for legacy bit-slice consumers.

Behaviour:
- Reset (rst_n == 0 at a clk edge): buf = 0, fill = 0, overflow = 0. Consequently empty = 1, full = 0, out_valid = 0, out_data = 0, and rd_data = 0.
- Storage: one BUF_WIDTH shift register.
  - A push shifts left by 16 or 32 bits and inserts the new data at the LSBs.
  - The oldest data sits at bits [fill*16-1 -: 16/32].
  - A pop does not shift the register; it only decrements fill. Stale bits above fill remain visible on buf_flat and rd_data.
- Sizes: push_n = in_word ? 1 : 2; pop_n = out_word ? 1 : 2.
- out_valid = (fill >= pop_n). out_data is combinational:
  - out_word = 0: buf[fill*16-1 -: 32].
  - out_word = 1: {16'd0, buf[fill*16-1 -: 16]}.
  - out_data = 0 when out_valid = 0.
- in_ready:
  - DISCARD_OLDEST = 1: constant 1.
  - DISCARD_OLDEST = 0: (fill - pop_act*pop_n + push_n) <= CAP, where pop_act = out_valid & out_ready. A simultaneous pop therefore frees space for the push in the same cycle.
- Accepted events: push_act = in_valid & in_ready; pop_act = out_valid & out_ready. Both may occur in one cycle. Pop is logically first: it reads the pre-push oldest data.
- Fill update: t = fill - pop_act*pop_n + push_act*push_n. fill_next = min(t, CAP).
- Overflow (set, never cleared except by clear or reset):
  - t > CAP with DISCARD_OLDEST = 1. The oldest bits are lost.
  - in_valid & ~in_ready with DISCARD_OLDEST = 0. The push is ignored.
- clear: has priority over push and pop in the same cycle. fill = 0, overflow = 0, buf = 0.
- rd_data is combinational and independent of fill. The task-switch EIP is extracted with rd_offset = 25 (bits 431:400 at BUF_WIDTH = 464).
- Latency: all state updates take effect on the next clk edge. out_data, in_ready and rd_data are combinational.
- Reset asserted mid-sequence: the result is identical to the reset state on the next edge, regardless of in_valid/out_ready.

Decomposition:
- Shared package (defines.v style): the halfword size constant 16, the task-switch EIP offset constant (25), and a helper macro for CNT_W.
- One natural sub-module, exe_shift_buffer_rdmux: the indexed 32-bit extract with zero-fill. It is instantiated twice, once for the rd_data port and once for out_data.

Test Plan:
- Reset and legacy fill: push 15 dwords 0x0000_0001..0x0000_000F (30 slots > CAP = 29) with DISCARD_OLDEST = 1.
  - Required: fill = 29, overflow = 1, buf_flat[31:0] = 0xF, rd_data(offset 2) = 0xE.
- Mixed sizes: push word 0xAAAA, then dword 0x1234_5678.
  - Required: fill = 3, buf_flat[47:0] = 0xAAAA_1234_5678.
  - Word pop: out_data = 0x0000_AAAA, then fill = 2.
  - Dword pop: out_data = 0x1234_5678, then empty = 1.
- Refusal mode: DISCARD_OLDEST = 0, fill = 28, dword push.
  - Required: in_ready = 0, overflow = 1, fill stays 28.
  - Same push with a simultaneous dword pop: in_ready = 1, fill stays 28, and the old oldest dword is returned on out_data.
- Underflow guard: fill = 1 with a dword pop request.
  - Required: out_valid = 0, out_data = 0, fill unchanged.
  - A word pop succeeds.
- Clear priority: clear together with push and pop at fill = 10, overflow = 1.
  - Required next cycle: fill = 0, overflow = 0, buf_flat = 0.
- Synchronous reset: assert rst_n = 0 for one edge with in_valid = 1.
  - Required: all outputs equal their reset values, and no push is recorded.
